life_seq_ctrl: RTL and testbench

//  Sequencer for the 4x4 life array. Owns the array's row/col/val/write_enb and run inputs.

---
 rtl/life_seq_ctrl_if.sv | 30 +++
 rtl/life_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_life_seq_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/life_seq_ctrl_if.sv
// Interface bundling the sequencer's request inputs and array/status outputs.
// master drives requests and observes the array bus; slave is the sequencer side.
interface life_seq_ctrl_if #(
    parameter int GEN_W = 16
);
    logic             tick;
    logic             frame;
    logic             run_enb;
    logic             step_req;
    logic             load_req;
    logic [15:0]      pattern;
    logic             clear_req;
    logic [1:0]       row;
    logic [1:0]       col;
    logic             val;
    logic             write_enb;
    logic             run;
    logic             busy;
    logic [GEN_W-1:0] gen_count;

    modport master (
        output tick, frame, run_enb, step_req, load_req, pattern, clear_req,
        input  row, col, val, write_enb, run, busy, gen_count
    );

    modport slave (
        input  tick, frame, run_enb, step_req, load_req, pattern, clear_req,
        output row, col, val, write_enb, run, busy, gen_count
    );
endinterface

// File: rtl/life_seq_ctrl.sv
// Sequencer for the 4x4 life array: serial seed load / board clear, one cell
// per clock, and generation-advance pulses optionally aligned to the frame strobe.
module life_seq_ctrl #(
    parameter int GEN_W      = 16,
    parameter int FRAME_SYNC = 1
) (
    input logic             clk,
    input logic             reset,
    life_seq_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic             WAIT_FRAME = (FRAME_SYNC != 0);
    localparam logic [GEN_W-1:0] GEN_ONE    = {{(GEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r,   state_nxt_s;
    logic [3:0]       idx_r,     idx_nxt_s;
    logic [15:0]      shadow_r,  shadow_nxt_s;
    logic             pending_r, pending_nxt_s;
    logic [1:0]       row_r,     row_nxt_s;
    logic [1:0]       col_r,     col_nxt_s;
    logic             val_r,     val_nxt_s;
    logic             we_r,      we_nxt_s;
    logic             run_r,     run_nxt_s;
    logic             busy_r,    busy_nxt_s;
    logic [GEN_W-1:0] gen_r,     gen_nxt_s;

    logic [3:0]       idx_inc_s;
    logic             gen_req_s;

    assign idx_inc_s = idx_r + 4'd1;
    assign gen_req_s = (bus.tick & bus.run_enb) | bus.step_req;

    // Next-state and next-output decode; outputs describe the cell written in the following cycle.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        shadow_nxt_s  = shadow_r;
        pending_nxt_s = pending_r;
        row_nxt_s     = 2'd0;
        col_nxt_s     = 2'd0;
        val_nxt_s     = 1'b0;
        we_nxt_s      = 1'b0;
        run_nxt_s     = 1'b0;
        busy_nxt_s    = 1'b0;
        gen_nxt_s     = gen_r;

        if (bus.clear_req) begin
            state_nxt_s   = ST_CLEAR;
            idx_nxt_s     = 4'd0;
            pending_nxt_s = 1'b0;
            gen_nxt_s     = {GEN_W{1'b0}};
            we_nxt_s      = 1'b1;
            busy_nxt_s    = 1'b1;
        end else if (bus.load_req && (state_r == ST_IDLE)) begin
            state_nxt_s   = ST_LOAD;
            idx_nxt_s     = 4'd0;
            shadow_nxt_s  = bus.pattern;
            pending_nxt_s = 1'b0;
            gen_nxt_s     = {GEN_W{1'b0}};
            we_nxt_s      = 1'b1;
            busy_nxt_s    = 1'b1;
            val_nxt_s     = bus.pattern[0];
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A request arriving in the issue cycle is absorbed by the pulse being issued.
                    if (pending_r && (!WAIT_FRAME || bus.frame)) begin
                        run_nxt_s     = 1'b1;
                        pending_nxt_s = 1'b0;
                        gen_nxt_s     = gen_r + GEN_ONE;
                    end else begin
                        pending_nxt_s = pending_r | gen_req_s;
                    end
                end
                ST_LOAD, ST_CLEAR: begin
                    pending_nxt_s = pending_r | gen_req_s;
                    if (idx_r == 4'd15) begin
                        state_nxt_s = ST_IDLE;
                        idx_nxt_s   = 4'd0;
                    end else begin
                        idx_nxt_s  = idx_inc_s;
                        we_nxt_s   = 1'b1;
                        busy_nxt_s = 1'b1;
                        row_nxt_s  = idx_inc_s[3:2];
                        col_nxt_s  = idx_inc_s[1:0];
                        val_nxt_s  = (state_r == ST_LOAD) ? shadow_r[idx_inc_s] : 1'b0;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // State and registered outputs; reset returns everything to zero at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            shadow_r  <= 16'd0;
            pending_r <= 1'b0;
            row_r     <= 2'd0;
            col_r     <= 2'd0;
            val_r     <= 1'b0;
            we_r      <= 1'b0;
            run_r     <= 1'b0;
            busy_r    <= 1'b0;
            gen_r     <= {GEN_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            shadow_r  <= shadow_nxt_s;
            pending_r <= pending_nxt_s;
            row_r     <= row_nxt_s;
            col_r     <= col_nxt_s;
            val_r     <= val_nxt_s;
            we_r      <= we_nxt_s;
            run_r     <= run_nxt_s;
            busy_r    <= busy_nxt_s;
            gen_r     <= gen_nxt_s;
        end
    end

    assign bus.row       = row_r;
    assign bus.col       = col_r;
    assign bus.val       = val_r;
    assign bus.write_enb = we_r;
    assign bus.run       = run_r;
    assign bus.busy      = busy_r;
    assign bus.gen_count = gen_r;

endmodule

// File: tb/tb_life_seq_ctrl.sv
// Bench: two sequencers (GEN_W=16 frame-synced, GEN_W=2 free-issue) share stimulus
// and are compared every cycle against a cell-countdown reference model.
module tb_life_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0, frame = 1'b0, run_enb = 1'b0;
    logic        step_req = 1'b0, load_req = 1'b0, clear_req = 1'b0;
    logic [15:0] pattern = 16'd0;

    int checks = 0;
    int failures = 0;

    life_seq_ctrl_if #(.GEN_W(16)) if_a ();
    life_seq_ctrl_if #(.GEN_W(2))  if_b ();

    assign if_a.tick = tick;         assign if_b.tick = tick;
    assign if_a.frame = frame;       assign if_b.frame = frame;
    assign if_a.run_enb = run_enb;   assign if_b.run_enb = run_enb;
    assign if_a.step_req = step_req; assign if_b.step_req = step_req;
    assign if_a.load_req = load_req; assign if_b.load_req = load_req;
    assign if_a.pattern = pattern;   assign if_b.pattern = pattern;
    assign if_a.clear_req = clear_req; assign if_b.clear_req = clear_req;

    life_seq_ctrl #(.GEN_W(16), .FRAME_SYNC(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    life_seq_ctrl #(.GEN_W(2),  .FRAME_SYNC(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    always #5 clk = ~clk;

    // Reference model: cells still to write, cell on the bus, pending request, generation.
    int          left_m [2];
    int          cur_m  [2];
    int          gen_m  [2];
    bit          clr_m  [2];
    bit          pend_m [2];
    logic [15:0] shad_m [2];
    bit          e_run  [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            left_m[m] = 0; cur_m[m] = 0; gen_m[m] = 0;
            clr_m[m] = 1'b0; pend_m[m] = 1'b0; shad_m[m] = 16'd0; e_run[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input bit sync, input int gw);
        bit idle;
        idle = (left_m[m] == 0);
        e_run[m] = 1'b0;
        if (clear_req) begin
            left_m[m] = 16; cur_m[m] = 0; clr_m[m] = 1'b1; pend_m[m] = 1'b0; gen_m[m] = 0;
        end else if (load_req && idle) begin
            left_m[m] = 16; cur_m[m] = 0; clr_m[m] = 1'b0; shad_m[m] = pattern;
            pend_m[m] = 1'b0; gen_m[m] = 0;
        end else begin
            if (!idle) begin
                left_m[m]--;
                cur_m[m]++;
            end
            if (idle && pend_m[m] && (!sync || frame)) begin
                e_run[m] = 1'b1;
                pend_m[m] = 1'b0;
                gen_m[m] = (gen_m[m] + 1) % (1 << gw);
            end else if (step_req || (tick && run_enb)) begin
                pend_m[m] = 1'b1;
            end
        end
    endtask

    task automatic check_dut(input int m);
        logic [31:0] o_we, o_row, o_col, o_val, o_run, o_busy, o_gen;
        bit wr;
        string nm;
        logic [15:0] sh;
        nm = (m == 0) ? "a" : "b";
        if (m == 0) begin
            o_we = {31'd0, if_a.write_enb}; o_row = {30'd0, if_a.row}; o_col = {30'd0, if_a.col};
            o_val = {31'd0, if_a.val}; o_run = {31'd0, if_a.run}; o_busy = {31'd0, if_a.busy};
            o_gen = {16'd0, if_a.gen_count};
        end else begin
            o_we = {31'd0, if_b.write_enb}; o_row = {30'd0, if_b.row}; o_col = {30'd0, if_b.col};
            o_val = {31'd0, if_b.val}; o_run = {31'd0, if_b.run}; o_busy = {31'd0, if_b.busy};
            o_gen = {30'd0, if_b.gen_count};
        end
        wr = (left_m[m] > 0);
        sh = shad_m[m];
        check_val({nm, "_write_enb"}, o_we, {31'd0, wr});
        check_val({nm, "_busy"}, o_busy, {31'd0, wr});
        check_val({nm, "_row"}, o_row, wr ? 32'(cur_m[m] / 4) : 32'd0);
        check_val({nm, "_col"}, o_col, wr ? 32'(cur_m[m] % 4) : 32'd0);
        check_val({nm, "_val"}, o_val, (wr && !clr_m[m]) ? {31'd0, sh[cur_m[m]]} : 32'd0);
        check_val({nm, "_run"}, o_run, {31'd0, e_run[m]});
        check_val({nm, "_gen_count"}, o_gen, 32'(gen_m[m]));
    endtask

    task automatic run_cycle();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            model_step(0, 1'b1, 16);
            model_step(1, 1'b0, 2);
        end
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic quiet(input int n);
        tick = 1'b0; frame = 1'b0; step_req = 1'b0; load_req = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic pulse_load(input logic [15:0] p);
        load_req = 1'b1; pattern = p;
        run_cycle();
        load_req = 1'b0;
    endtask

    initial begin
        model_reset();
        run_cycle();
        run_cycle();
        reset = 1'b0;
        quiet(2);

        // seed load with a diagonal pattern
        pulse_load(16'h8421);
        quiet(18);

        // free-run tick, frame ten cycles later, then frames with no tick
        run_enb = 1'b1;
        tick = 1'b1;
        run_cycle();
        quiet(9);
        frame = 1'b1; run_cycle();
        quiet(4);
        for (int k = 0; k < 3; k++) begin
            frame = 1'b1; run_cycle();
            quiet(5);
        end

        // tick coinciding with frame while nothing pending waits for the next frame
        tick = 1'b1; frame = 1'b1; run_cycle();
        quiet(3);
        frame = 1'b1; run_cycle();
        quiet(3);
        run_enb = 1'b0;

        // step and tick together yield a single pending request
        step_req = 1'b1; tick = 1'b1; run_cycle();
        quiet(2);
        for (int k = 0; k < 2; k++) begin
            frame = 1'b1; run_cycle();
            quiet(3);
        end

        // clear aborts load at idx 5; load during clear is ignored
        pulse_load(16'hFFFF);
        quiet(5);
        clear_req = 1'b1; run_cycle();
        quiet(3);
        pulse_load(16'hA5A5);
        quiet(16);

        // five steps, each served by a frame: narrow counter wraps
        for (int k = 0; k < 5; k++) begin
            step_req = 1'b1; run_cycle();
            quiet(1);
            frame = 1'b1; run_cycle();
            quiet(2);
        end

        // asynchronous reset in the middle of a load
        pulse_load(16'h1234);
        quiet(7);
        #2 reset = 1'b1;
        #1 model_reset();
        check_dut(0);
        check_dut(1);
        run_cycle();
        reset = 1'b0;
        quiet(20);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick      = ($urandom_range(7) == 0);
            frame     = ($urandom_range(11) == 0);
            step_req  = ($urandom_range(29) == 0);
            load_req  = ($urandom_range(59) == 0);
            clear_req = ($urandom_range(149) == 0);
            pattern   = 16'($urandom);
            if ($urandom_range(49) == 0) run_enb = ~run_enb;
            run_cycle();
        end
        quiet(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
